// File: rtl/aquila_mem_arbiter_pkg.sv
// Shared encodings for the Aquila memory arbiter: FSM states and port-select values.
package aquila_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } arb_state_e;

   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/aquila_mem_arbiter_if.sv
// Bus bundle between the Aquila I/D cache ports, the arbiter and the memory controller.
interface aquila_mem_arbiter_if #(
   parameter int XLEN   = 32,
   parameter int CLSIZE = 128
);
   logic              I_strobe_i;
   logic [XLEN-1:0]   I_addr_i;
   logic              I_done_o;
   logic [CLSIZE-1:0] I_data_o;

   logic              D_strobe_i;
   logic [XLEN-1:0]   D_addr_i;
   logic              D_rw_i;
   logic [CLSIZE-1:0] D_data_i;
   logic              D_done_o;
   logic [CLSIZE-1:0] D_data_o;

   logic              MEM_strobe_o;
   logic [XLEN-1:0]   MEM_addr_o;
   logic              MEM_rw_o;
   logic [CLSIZE-1:0] MEM_data_o;
   logic              MEM_done_i;
   logic [CLSIZE-1:0] MEM_data_i;

   // The arbiter's view.
   modport slave (
      input  I_strobe_i, I_addr_i, D_strobe_i, D_addr_i, D_rw_i, D_data_i,
      input  MEM_done_i, MEM_data_i,
      output I_done_o, I_data_o, D_done_o, D_data_o,
      output MEM_strobe_o, MEM_addr_o, MEM_rw_o, MEM_data_o
   );

   // The surrounding system's view: cache ports plus memory controller.
   modport master (
      output I_strobe_i, I_addr_i, D_strobe_i, D_addr_i, D_rw_i, D_data_i,
      output MEM_done_i, MEM_data_i,
      input  I_done_o, I_data_o, D_done_o, D_data_o,
      input  MEM_strobe_o, MEM_addr_o, MEM_rw_o, MEM_data_o
   );
endinterface

// File: rtl/aquila_mem_arbiter_arb_req_latch.sv
// arb_req_latch: per-port pending flag plus captured address/rw/data of one request.
module aquila_mem_arbiter_arb_req_latch #(
   parameter int XLEN   = 32,
   parameter int CLSIZE = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              strobe,
   input  logic [XLEN-1:0]   addr,
   input  logic              rw,
   input  logic [CLSIZE-1:0] data,
   input  logic              busy,
   input  logic              clr,
   output logic              pend,
   output logic [XLEN-1:0]   addr_q,
   output logic              rw_q,
   output logic [CLSIZE-1:0] data_q
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pend   <= 1'b0;
         addr_q <= '0;
         rw_q   <= 1'b0;
         data_q <= '0;
      end else if (clr) begin
         pend <= 1'b0;
      end else if (strobe && !pend && !busy) begin
         pend   <= 1'b1;
         addr_q <= addr;
         rw_q   <= rw;
         data_q <= data;
      end
   end

endmodule

// File: rtl/aquila_mem_arbiter.sv
// Merges the Aquila I-cache and D-cache line ports onto one memory port: one transaction
// in flight, D-over-I priority bounded by MAX_D_BURST, and a sticky WAIT watchdog.
module aquila_mem_arbiter
   import aquila_mem_arbiter_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int CLSIZE      = 128,
   parameter int MAX_D_BURST = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                clk_i,
   input  logic                rst_i,
   aquila_mem_arbiter_if.slave bus,
   output logic                timeout_o
);

   localparam int BURST_W = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;
   localparam int WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);
   localparam logic [WD_W-1:0]    WD_LAST   = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   arb_state_e        state_q, state_d;
   logic              sel_q;
   logic [XLEN-1:0]   mem_addr_q;
   logic              mem_rw_q;
   logic [CLSIZE-1:0] mem_data_q;
   logic [BURST_W-1:0] d_burst_q;
   logic [WD_W-1:0]   wd_q;
   logic              timeout_q;
   logic [CLSIZE-1:0] i_rdata_q, d_rdata_q;

   logic              pend_i, pend_d, busy_i, busy_d, clr_i, clr_d;
   logic [XLEN-1:0]   i_addr_q, d_addr_q;
   logic              i_rw_q, d_rw_q;
   logic [CLSIZE-1:0] i_wdata_q, d_wdata_q;
   logic              win_d, wd_fire, mem_strobe, i_done, d_done;

   // I requests are always line reads, so their rw/data capture is tied to zero.
   aquila_mem_arbiter_arb_req_latch #(.XLEN(XLEN), .CLSIZE(CLSIZE)) u_i_req (
      .clk_i(clk_i), .rst_i(rst_i), .strobe(bus.I_strobe_i), .addr(bus.I_addr_i),
      .rw(1'b0), .data({CLSIZE{1'b0}}), .busy(busy_i), .clr(clr_i),
      .pend(pend_i), .addr_q(i_addr_q), .rw_q(i_rw_q), .data_q(i_wdata_q)
   );

   aquila_mem_arbiter_arb_req_latch #(.XLEN(XLEN), .CLSIZE(CLSIZE)) u_d_req (
      .clk_i(clk_i), .rst_i(rst_i), .strobe(bus.D_strobe_i), .addr(bus.D_addr_i),
      .rw(bus.D_rw_i), .data(bus.D_data_i), .busy(busy_d), .clr(clr_d),
      .pend(pend_d), .addr_q(d_addr_q), .rw_q(d_rw_q), .data_q(d_wdata_q)
   );

   assign busy_i  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (sel_q == SEL_I);
   assign busy_d  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (sel_q == SEL_D);
   assign win_d   = pend_d && !(pend_i && (d_burst_q == BURST_MAX));
   assign wd_fire = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      mem_strobe = 1'b0;
      clr_i      = 1'b0;
      clr_d      = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      case (state_q)
         S_IDLE:  if (pend_i || pend_d) state_d = S_ISSUE;
         S_ISSUE: begin
            mem_strobe = 1'b1;
            clr_i      = (sel_q == SEL_I);
            clr_d      = (sel_q == SEL_D);
            state_d    = S_WAIT;
         end
         S_WAIT:  if (bus.MEM_done_i || wd_fire) state_d = S_RESP;
         S_RESP: begin
            i_done  = (sel_q == SEL_I);
            d_done  = (sel_q == SEL_D);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the line-wide registers are reset as well, since every output must read zero after reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sel_q      <= SEL_I;
         mem_addr_q <= '0;
         mem_rw_q   <= 1'b0;
         mem_data_q <= '0;
         d_burst_q  <= '0;
         wd_q       <= '0;
         timeout_q  <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (pend_i || pend_d) begin
               sel_q      <= win_d ? SEL_D : SEL_I;
               mem_addr_q <= win_d ? d_addr_q : i_addr_q;
               mem_rw_q   <= win_d ? d_rw_q : i_rw_q;
               mem_data_q <= win_d ? d_wdata_q : i_wdata_q;
               if (win_d && pend_i) begin
                  if (d_burst_q != BURST_MAX) d_burst_q <= d_burst_q + 1'b1;
               end else begin
                  d_burst_q <= '0;
               end
            end
            S_ISSUE: wd_q <= '0;
            S_WAIT: begin
               if (bus.MEM_done_i) begin
                  if (sel_q == SEL_D) d_rdata_q <= bus.MEM_data_i;
                  else                i_rdata_q <= bus.MEM_data_i;
               end else if (wd_fire) begin
                  timeout_q <= 1'b1;
                  if (sel_q == SEL_D) d_rdata_q <= '0;
                  else                i_rdata_q <= '0;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.MEM_strobe_o = mem_strobe;
   assign bus.MEM_addr_o   = mem_addr_q;
   assign bus.MEM_rw_o     = mem_rw_q;
   assign bus.MEM_data_o   = mem_data_q;
   assign bus.I_done_o     = i_done;
   assign bus.I_data_o     = i_rdata_q;
   assign bus.D_done_o     = d_done;
   assign bus.D_data_o     = d_rdata_q;
   assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_aquila_mem_arbiter.sv
// Directed bench for aquila_mem_arbiter: a small memory-controller model plus one task per scenario.
module tb_aquila_mem_arbiter;

   localparam int XLEN        = 32;
   localparam int CLSIZE      = 128;
   localparam int MAX_D_BURST = 2;
   localparam int TIMEOUT_CYC = 16;

   logic clk_i;
   logic rst_i;
   logic timeout_o;

   aquila_mem_arbiter_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus ();

   aquila_mem_arbiter #(
      .XLEN(XLEN), .CLSIZE(CLSIZE), .MAX_D_BURST(MAX_D_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .timeout_o(timeout_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Memory model knobs, written only by the test sequence.
   int                mem_lat     = 0;
   logic [CLSIZE-1:0] mem_rdata   = '0;
   int                stray_req_n = 0;

   // Grant log and model state, written only by the memory model.
   logic [XLEN-1:0]   g_addr[$];
   logic              g_rw[$];
   logic [CLSIZE-1:0] g_data[$];
   int                g_cyc[$];
   int                unstable_cnt = 0;
   int                stray_ack_n  = 0;
   int                resp_cnt     = 0;
   logic [XLEN-1:0]   cur_addr;
   logic              cur_rw;
   logic [CLSIZE-1:0] cur_data;

   // Done-pulse log, written only by the done monitor.
   int                i_done_cnt = 0;
   int                d_done_cnt = 0;
   int                i_done_cyc = 0;
   int                d_done_cyc = 0;
   logic [CLSIZE-1:0] i_done_data = '0;
   logic [CLSIZE-1:0] d_done_data = '0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin : mem_model
      bus.MEM_done_i = 1'b0;
      bus.MEM_data_i = '0;
      forever begin
         @(negedge clk_i);
         bus.MEM_done_i = 1'b0;
         if (resp_cnt > 0) begin
            if (bus.MEM_addr_o !== cur_addr || bus.MEM_rw_o !== cur_rw || bus.MEM_data_o !== cur_data)
               unstable_cnt++;
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.MEM_done_i = 1'b1;
               bus.MEM_data_i = mem_rdata;
            end
         end else if (stray_req_n != stray_ack_n) begin
            bus.MEM_done_i = 1'b1;
            bus.MEM_data_i = {4{32'hDEAD_BEEF}};
            stray_ack_n++;
         end
         if (bus.MEM_strobe_o === 1'b1) begin
            cur_addr = bus.MEM_addr_o;
            cur_rw   = bus.MEM_rw_o;
            cur_data = bus.MEM_data_o;
            g_addr.push_back(cur_addr);
            g_rw.push_back(cur_rw);
            g_data.push_back(cur_data);
            g_cyc.push_back(cyc);
            if (mem_lat > 0) resp_cnt = mem_lat;
         end
      end
   end

   initial begin : done_monitor
      forever begin
         @(negedge clk_i);
         if (bus.I_done_o === 1'b1) begin
            i_done_cnt++;
            i_done_cyc  = cyc;
            i_done_data = bus.I_data_o;
         end
         if (bus.D_done_o === 1'b1) begin
            d_done_cnt++;
            d_done_cyc  = cyc;
            d_done_data = bus.D_data_o;
         end
      end
   end

   initial begin : global_guard
      #200000;
      $display("FAIL global_guard: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_i);
         #1;
      end
   endtask

   task automatic wait_for(input int i_tgt, input int d_tgt, input int g_tgt, input int budget,
                           output bit ok);
      int n;
      n = 0;
      while ((i_done_cnt < i_tgt || d_done_cnt < d_tgt || g_addr.size() < g_tgt) && n < budget) begin
         tick(1);
         n++;
      end
      ok = (i_done_cnt >= i_tgt && d_done_cnt >= d_tgt && g_addr.size() >= g_tgt);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      bus.I_strobe_i = 1'b0; bus.I_addr_i = '0;
      bus.D_strobe_i = 1'b0; bus.D_addr_i = '0; bus.D_rw_i = 1'b0; bus.D_data_i = '0;
      tick(3);
      n_checks++;
      if ({bus.MEM_strobe_o, bus.I_done_o, bus.D_done_o, bus.MEM_rw_o, timeout_o} !== 5'b0)
         $display("FAIL reset_ctrl: got %b want 00000",
                  {bus.MEM_strobe_o, bus.I_done_o, bus.D_done_o, bus.MEM_rw_o, timeout_o});
      else n_pass++;
      n_checks++;
      if ({bus.MEM_addr_o, bus.MEM_data_o, bus.I_data_o, bus.D_data_o} !== '0)
         $display("FAIL reset_data: MEM_addr %h MEM_data %h want 0", bus.MEM_addr_o, bus.MEM_data_o);
      else n_pass++;
      rst_i = 1'b1;
      tick(4);
      n_checks++;
      if (g_addr.size() !== 0) $display("FAIL reset_idle: got %0d grants want 0", g_addr.size());
      else n_pass++;
   endtask

   task automatic test_i_only();
      int gi, ii, di, t0;
      bit ok;
      gi = g_addr.size(); ii = i_done_cnt; di = d_done_cnt;
      mem_lat = 5; mem_rdata = {4{32'hA5A5_A5A5}};
      t0 = cyc;
      bus.I_addr_i = 32'h8000_0040; bus.I_strobe_i = 1'b1;
      tick(1);
      bus.I_strobe_i = 1'b0; bus.I_addr_i = 32'h1234_5678;
      wait_for(ii + 1, di, gi + 1, 40, ok);
      tick(4);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL i_only_wait: got %0d I dones want %0d", i_done_cnt, ii + 1);
      else n_pass++;
      n_checks++;
      if (g_addr[gi] !== 32'h8000_0040 || g_rw[gi] !== 1'b0 || g_data[gi] !== '0)
         $display("FAIL i_only_issue: addr %h rw %b data %h want 80000040/0/0", g_addr[gi], g_rw[gi], g_data[gi]);
      else n_pass++;
      n_checks++;
      if (g_cyc[gi] !== t0 + 2) $display("FAIL i_only_strobe_lat: cycle %0d want %0d", g_cyc[gi], t0 + 2);
      else n_pass++;
      n_checks++;
      if (i_done_cyc !== t0 + 8) $display("FAIL i_only_done_lat: cycle %0d want %0d", i_done_cyc, t0 + 8);
      else n_pass++;
      n_checks++;
      if (i_done_data !== {4{32'hA5A5_A5A5}}) $display("FAIL i_only_data: got %h want a5..a5", i_done_data);
      else n_pass++;
      n_checks++;
      if (i_done_cnt !== ii + 1 || d_done_cnt !== di || g_addr.size() !== gi + 1)
         $display("FAIL i_only_pulses: I %0d D %0d grants %0d want %0d %0d %0d",
                  i_done_cnt, d_done_cnt, g_addr.size(), ii + 1, di, gi + 1);
      else n_pass++;
      n_checks++;
      if (bus.I_data_o !== {4{32'hA5A5_A5A5}}) $display("FAIL i_only_hold: got %h want a5..a5", bus.I_data_o);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      int gi, ii, di, t0;
      bit ok;
      gi = g_addr.size(); ii = i_done_cnt; di = d_done_cnt;
      mem_lat = 3; mem_rdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      t0 = cyc;
      bus.I_addr_i = 32'h8000_0080; bus.I_strobe_i = 1'b1;
      bus.D_addr_i = 32'h8000_1000; bus.D_rw_i = 1'b0; bus.D_strobe_i = 1'b1;
      tick(1);
      bus.I_strobe_i = 1'b0; bus.D_strobe_i = 1'b0;
      wait_for(ii + 1, di + 1, gi + 2, 60, ok);
      tick(4);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL simul_wait: I %0d D %0d dones", i_done_cnt, d_done_cnt);
      else n_pass++;
      n_checks++;
      if (g_addr[gi] !== 32'h8000_1000 || g_addr[gi+1] !== 32'h8000_0080 || g_addr.size() !== gi + 2)
         $display("FAIL simul_order: got %h,%h (%0d grants) want 80001000,80000080",
                  g_addr[gi], g_addr[gi+1], g_addr.size() - gi);
      else n_pass++;
      n_checks++;
      if (d_done_cyc !== t0 + 6 || i_done_cyc !== t0 + 12)
         $display("FAIL simul_timing: D at %0d I at %0d want %0d %0d", d_done_cyc, i_done_cyc, t0 + 6, t0 + 12);
      else n_pass++;
      n_checks++;
      if (d_done_data !== 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF)
         $display("FAIL simul_d_data: got %h", d_done_data);
      else n_pass++;
   endtask

   task automatic test_starvation();
      int gi;
      bit ok;
      logic [XLEN-1:0] exp_seq [6];
      exp_seq[0] = 32'h8000_3000; exp_seq[1] = 32'h8000_3000; exp_seq[2] = 32'h8000_0100;
      exp_seq[3] = 32'h8000_3000; exp_seq[4] = 32'h8000_3000; exp_seq[5] = 32'h8000_0100;
      gi = g_addr.size();
      mem_lat = 1;
      bus.I_addr_i = 32'h8000_0100; bus.D_addr_i = 32'h8000_3000; bus.D_rw_i = 1'b0;
      bus.I_strobe_i = 1'b1; bus.D_strobe_i = 1'b1;
      wait_for(0, 0, gi + 6, 200, ok);
      bus.I_strobe_i = 1'b0; bus.D_strobe_i = 1'b0;
      tick(30);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL starve_wait: got %0d grants want 6", g_addr.size() - gi);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (g_addr[gi+k] !== exp_seq[k])
            $display("FAIL starve_grant%0d: got %h want %h", k, g_addr[gi+k], exp_seq[k]);
         else n_pass++;
      end
   endtask

   task automatic test_write();
      int gi, di, uc, t0;
      bit ok;
      logic [CLSIZE-1:0] wdata;
      wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      gi = g_addr.size(); di = d_done_cnt; uc = unstable_cnt;
      mem_lat = 8;
      t0 = cyc;
      bus.D_addr_i = 32'h8000_2000; bus.D_rw_i = 1'b1; bus.D_data_i = wdata; bus.D_strobe_i = 1'b1;
      tick(1);
      bus.D_strobe_i = 1'b0; bus.D_addr_i = 32'hFFFF_FFFF; bus.D_rw_i = 1'b0; bus.D_data_i = ~wdata;
      wait_for(0, di + 1, gi + 1, 40, ok);
      tick(2);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL write_wait: D dones %0d want %0d", d_done_cnt, di + 1);
      else n_pass++;
      n_checks++;
      if (g_addr[gi] !== 32'h8000_2000 || g_rw[gi] !== 1'b1)
         $display("FAIL write_issue: addr %h rw %b want 80002000/1", g_addr[gi], g_rw[gi]);
      else n_pass++;
      n_checks++;
      if (g_data[gi] !== wdata) $display("FAIL write_data: got %h want %h", g_data[gi], wdata);
      else n_pass++;
      n_checks++;
      if (unstable_cnt !== uc) $display("FAIL write_stable: %0d unstable cycles want 0", unstable_cnt - uc);
      else n_pass++;
      n_checks++;
      if (d_done_cyc !== t0 + 11) $display("FAIL write_done_lat: cycle %0d want %0d", d_done_cyc, t0 + 11);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int gi, ii, di, t0;
      bit ok;
      gi = g_addr.size(); ii = i_done_cnt; di = d_done_cnt;
      n_checks++;
      if (timeout_o !== 1'b0) $display("FAIL timeout_pre: got %b want 0", timeout_o);
      else n_pass++;
      mem_lat = 0;
      t0 = cyc;
      bus.D_addr_i = 32'h8000_4000; bus.D_rw_i = 1'b0; bus.D_strobe_i = 1'b1;
      tick(1);
      bus.D_strobe_i = 1'b0;
      wait_for(0, di + 1, gi + 1, 60, ok);
      tick(1);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL timeout_wait: D dones %0d want %0d", d_done_cnt, di + 1);
      else n_pass++;
      n_checks++;
      if (d_done_cyc !== t0 + 19) $display("FAIL timeout_cycle: cycle %0d want %0d", d_done_cyc, t0 + 19);
      else n_pass++;
      n_checks++;
      if (d_done_data !== '0 || timeout_o !== 1'b1)
         $display("FAIL timeout_flag: data %h flag %b want 0/1", d_done_data, timeout_o);
      else n_pass++;
      mem_lat = 2; mem_rdata = {4{32'hCAFE_F00D}};
      bus.I_addr_i = 32'h8000_0200; bus.I_strobe_i = 1'b1;
      tick(1);
      bus.I_strobe_i = 1'b0;
      wait_for(ii + 1, 0, gi + 2, 40, ok);
      tick(2);
      n_checks++;
      if (ok !== 1'b1 || g_addr[gi+1] !== 32'h8000_0200 || i_done_data !== {4{32'hCAFE_F00D}})
         $display("FAIL timeout_recover: ok %b addr %h data %h", ok, g_addr[gi+1], i_done_data);
      else n_pass++;
      n_checks++;
      if (timeout_o !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      int gi, ii, di;
      bit ok;
      gi = g_addr.size();
      mem_lat = 0;
      bus.D_addr_i = 32'h8000_5000; bus.D_rw_i = 1'b0; bus.D_strobe_i = 1'b1;
      tick(1);
      bus.D_strobe_i = 1'b0;
      wait_for(0, 0, gi + 1, 20, ok);
      tick(3);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL rstwait_issue: got %0d grants want 1", g_addr.size() - gi);
      else n_pass++;
      rst_i = 1'b0;
      tick(1);
      n_checks++;
      if ({bus.MEM_strobe_o, bus.I_done_o, bus.D_done_o, bus.MEM_rw_o, timeout_o} !== 5'b0 ||
          {bus.MEM_addr_o, bus.MEM_data_o, bus.I_data_o, bus.D_data_o} !== '0)
         $display("FAIL rstwait_outputs: addr %h I_data %h timeout %b want all 0",
                  bus.MEM_addr_o, bus.I_data_o, timeout_o);
      else n_pass++;
      tick(1);
      rst_i = 1'b1;
      tick(2);
      ii = i_done_cnt; di = d_done_cnt;
      stray_req_n++;
      tick(6);
      n_checks++;
      if (i_done_cnt !== ii || d_done_cnt !== di)
         $display("FAIL rstwait_stray: I %0d D %0d dones want %0d %0d", i_done_cnt, d_done_cnt, ii, di);
      else n_pass++;
      n_checks++;
      if (g_addr.size() !== gi + 1 || bus.MEM_addr_o !== '0 || bus.D_data_o !== '0)
         $display("FAIL rstwait_idle: grants %0d addr %h D_data %h want %0d/0/0",
                  g_addr.size(), bus.MEM_addr_o, bus.D_data_o, gi + 1);
      else n_pass++;
      mem_lat = 2; mem_rdata = {4{32'h600D_0001}};
      bus.I_addr_i = 32'h8000_0300; bus.I_strobe_i = 1'b1;
      tick(1);
      bus.I_strobe_i = 1'b0;
      wait_for(ii + 1, 0, gi + 2, 40, ok);
      n_checks++;
      if (ok !== 1'b1 || g_addr[gi+1] !== 32'h8000_0300 || i_done_data !== {4{32'h600D_0001}})
         $display("FAIL rstwait_next: ok %b addr %h data %h", ok, g_addr[gi+1], i_done_data);
      else n_pass++;
   endtask

   initial begin : main
      test_reset();
      test_i_only();
      test_simultaneous();
      test_starvation();
      test_write();
      test_timeout();
      test_reset_mid_wait();
      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
